// File: rtl/mul_seq_16_pkg.sv
// Shared definitions for the sequential 16x16 multiplier: FSM encoding and iteration count.
package mul_seq_16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] ITER_COUNT = 5'd16;
  localparam logic [CNT_W-1:0] CNT_LAST   = 5'd1;

endpackage

// File: rtl/mul_seq_16_add_17.sv
// Combinational add step of the shift-add multiplier: two operands in, carry-extended sum out.
module add_17 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_seq_16.sv
// Sequential unsigned multiplier: one shift-add step per cycle, fixed 17-cycle latency.
module mul_seq_16
  import mul_seq_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  add_17 #(.WIDTH(WIDTH)) u_add (
    .a   (acc_hi_q),
    .b   (mcand_q),
    .sum (sum)
  );

  // acc_lo starts as the multiplier and is consumed from the LSB as product bits shift in.
  assign step_hi = acc_lo_q[0] ? sum : {1'b0, acc_hi_q};
  assign next_hi = step_hi[WIDTH:1];
  assign next_lo = {step_hi[0], acc_lo_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          cnt_d    = ITER_COUNT;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_hi_d = next_hi;
        acc_lo_d = next_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_hi_d = next_hi;
          res_lo_d = next_lo;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mul_seq_16.sv
// Directed self-checking bench for mul_seq_16: latency, handshake, products, restart and reset.
module tb_mul_seq_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One multiply: start pulsed for one cycle, optional second start injected at run cycle poke_k.
  task automatic do_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [31:0] exp, input int poke_k);
    int          busy_cnt;
    int          lat;
    int          done_cnt;
    int          res_bad;
    logic [31:0] prev_res;
    logic [31:0] res_at_done;
    logic [31:0] res_now;
    busy_cnt    = 0;
    lat         = 0;
    done_cnt    = 0;
    res_bad     = 0;
    res_at_done = 32'hDEAD_BEEF;
    @(negedge clk);
    prev_res = {result_hi, result_lo};
    a        = ta;
    b        = tb_v;
    start    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      res_now = {result_hi, result_lo};
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat         = k;
          res_at_done = res_now;
        end
      end else if (lat == 0 && res_now !== prev_res) begin
        res_bad++;
      end
      if (lat != 0 && res_now !== res_at_done) res_bad++;
      if (k == poke_k) begin
        start = 1'b1;
        a     = 16'd2;
        b     = 16'd2;
      end else begin
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
      end
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd17);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_result"}, res_at_done, exp);
    check_eq({tag, "_result_stable"}, 32'(res_bad), 32'd0);
    $display("mul %s: a*b expected 0x%08h, got 0x%08h at cycle %0d", tag, exp, res_at_done, lat);
  endtask

  initial begin
    int          idle_cnt;
    int          done_cnt;
    int          last_done;
    int          bad_cnt;
    logic [31:0] res_now;

    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    #2;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_result", {result_hi, result_lo}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_mul("m3x5",       16'd3,    16'd5,    32'h0000_000F, 0);
    do_mul("mffff",      16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
    do_mul("m1234x0",    16'h1234, 16'h0000, 32'h0000_0000, 0);
    do_mul("m8000x2",    16'h8000, 16'h0002, 32'h0001_0000, 0);
    do_mul("m7x9_poke",  16'd7,    16'd9,    32'h0000_003F, 4);

    // start held high: back-to-back multiplies, a DONE cycle every 17 cycles
    idle_cnt  = 0;
    done_cnt  = 0;
    last_done = 0;
    bad_cnt   = 0;
    @(negedge clk);
    a     = 16'd4;
    b     = 16'd4;
    start = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (k - last_done != 17) bad_cnt++;
        if ({result_hi, result_lo} !== 32'h0000_0010) bad_cnt++;
        last_done = k;
      end
      if (!busy && !done) idle_cnt++;
      if (busy && done) bad_cnt++;
    end
    start = 1'b0;
    check_eq("cont_done_count", 32'(done_cnt), 32'd3);
    check_eq("cont_idle_cycles", 32'(idle_cnt), 32'd0);
    check_eq("cont_period_result", 32'(bad_cnt), 32'd0);
    check_eq("cont_result", {result_hi, result_lo}, 32'h0000_0010);
    $display("cont 4x4: %0d done pulses, %0d stray idle cycles", done_cnt, idle_cnt);
    repeat (2) @(negedge clk);

    // reset in the middle of a run
    a     = 16'd10;
    b     = 16'd10;
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_result", {result_hi, result_lo}, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    bad_cnt  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      res_now = {result_hi, result_lo};
      if (done) done_cnt++;
      if (busy) bad_cnt++;
      if (res_now !== 32'h0) bad_cnt++;
    end
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    check_eq("midrst_quiet", 32'(bad_cnt), 32'd0);
    $display("midrst 10x10: %0d done pulses after reset", done_cnt);

    do_mul("after_rst",  16'd12,   16'd11,   32'h0000_0084, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
